dem_to_io_ddr: RTL and testbench

- Transmit-side counterpart of the DDR byte-capture path on the 8-bit IO bus.
- Accepts 16-bit sample words from the internal datapath through a valid/ready stream and buffers them in a small FIFO.
- Drives each word onto the 8-bit IO bus as two bytes per clk cycle: high byte sampled by the far end on posedge, low byte sampled on negedge.
- Handles start-up priming, underflow and disable so the bus always carries a defined pattern.

---
 rtl/sdr_io_pkg.sv | 19 +
 rtl/sdr_sync_fifo.sv | 50 +++++
 rtl/dem_to_io_ddr.sv | 104 ++++++++++
 tb/tb_dem_to_io_ddr.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sdr_io_pkg.sv
// Shared types and widths for the sample-to-IO-bus transmit path.
package sdr_io_pkg;

  localparam int unsigned IO_BYTE_W   = 8;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned UFLOW_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    UNDERFLOW
  } io_tx_state_t;

  function automatic logic [UFLOW_CNT_W-1:0] sat_inc(input logic [UFLOW_CNT_W-1:0] v);
    return (&v) ? v : v + UFLOW_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sdr_sync_fifo.sv
// Single-clock FIFO with combinational head word; push and pop may coincide when full.
module sdr_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the push lands in, so full does not block a paired push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dem_to_io_ddr.sv
// Streams buffered 16-bit samples onto the 8-bit IO bus, high byte then low byte per clk.
module dem_to_io_ddr
  import sdr_io_pkg::*;
#(
  parameter int unsigned         DEPTH       = 4,
  parameter int unsigned         PRIME_LEVEL = 2,
  parameter logic [SAMPLE_W-1:0] IDLE_WORD   = 16'h0000,
  localparam int unsigned        LW          = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [SAMPLE_W-1:0]    s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [IO_BYTE_W-1:0]   IO_out,
  output logic                   io_active,
  output logic [UFLOW_CNT_W-1:0] underflow_cnt,
  output logic [LW-1:0]          fifo_level
);

  io_tx_state_t            state_q, state_d;
  logic [SAMPLE_W-1:0]     cur_word_q, cur_word_d;
  logic [UFLOW_CNT_W-1:0]  uflow_q, uflow_d;
  logic [IO_BYTE_W-1:0]    lo_q, hi_q;
  logic                    io_active_q;
  logic [SAMPLE_W-1:0]     fifo_head;
  logic                    fifo_full, fifo_empty;
  logic                    pop, push, primed;

  assign pop     = en && (state_q == RUN) && !fifo_empty;
  assign s_ready = !fifo_full || pop;
  assign push    = s_valid && s_ready;
  assign primed  = (fifo_level >= LW'(PRIME_LEVEL));

  sdr_sync_fifo #(
    .WIDTH(SAMPLE_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(s_data),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    cur_word_d = IDLE_WORD;
    uflow_d    = uflow_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: if (primed) state_d = RUN;
        RUN: begin
          if (pop) begin
            cur_word_d = fifo_head;
          end else begin
            state_d = UNDERFLOW;
            uflow_d = sat_inc(uflow_q);
          end
        end
        UNDERFLOW: begin
          uflow_d = sat_inc(uflow_q);
          if (primed) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // lo_q takes the outgoing word, so its low byte follows the high byte by half a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_word_q  <= IDLE_WORD;
      uflow_q     <= '0;
      lo_q        <= IDLE_WORD[IO_BYTE_W-1:0];
      io_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_word_q  <= cur_word_d;
      uflow_q     <= uflow_d;
      lo_q        <= cur_word_q[IO_BYTE_W-1:0];
      io_active_q <= pop;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) hi_q <= IDLE_WORD[SAMPLE_W-1:IO_BYTE_W];
    else     hi_q <= cur_word_q[SAMPLE_W-1:IO_BYTE_W];
  end

  assign IO_out        = clk ? lo_q : hi_q;
  assign io_active     = io_active_q;
  assign underflow_cnt = uflow_q;

endmodule

// File: tb/tb_dem_to_io_ddr.sv
// Scoreboard bench: accepted words are queued, a byte-bus receiver rebuilds and checks them.
module tb_dem_to_io_ddr;

  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          s_valid = 1'b0;
  logic [15:0]   s_data = 16'h0000;
  logic          s_ready;
  logic [7:0]    io_out;
  logic          io_active;
  logic [7:0]    underflow_cnt;
  logic [LW-1:0] fifo_level;

  int unsigned n_checks = 0;
  int unsigned n_fails = 0;
  logic [15:0] exp_q[$];
  logic        pending = 1'b0;
  logic [7:0]  hi_byte = 8'h00;

  int unsigned t1_lvl[8] = '{2, 2, 1, 0, 0, 0, 0, 0};
  int unsigned t1_act[8] = '{0, 0, 1, 1, 0, 0, 0, 0};

  dem_to_io_ddr #(
    .DEPTH      (4),
    .PRIME_LEVEL(2),
    .IDLE_WORD  (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .IO_out       (io_out),
    .io_active    (io_active),
    .underflow_cnt(underflow_cnt),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every word the DUT accepts must later appear on the bus, in order.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q.delete();
    else if (s_valid && s_ready) exp_q.push_back(s_data);
  end

  // Receiver: high byte in the low phase, low byte in the following high phase.
  initial begin
    logic [15:0] word;
    logic [15:0] exp_w;
    forever begin
      @(posedge clk); #2;
      if (rst) pending = 1'b0;
      if (pending) begin
        word = {hi_byte, io_out};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL rx_word: got %h, expected no word", word);
        end else begin
          exp_w = exp_q.pop_front();
          check("rx_word", word, exp_w);
        end
        pending = 1'b0;
      end else begin
        check("idle_lo_byte", io_out, 8'h00);
      end
      @(negedge clk); #2;
      if (rst) pending = 1'b0;
      if (io_active && !rst) begin
        hi_byte = io_out;
        pending = 1'b1;
      end else begin
        check("idle_hi_byte", io_out, 8'h00);
      end
    end
  end

  task automatic check_reset_state();
    check("rst_level", fifo_level, 0);
    check("rst_ready", s_ready, 1);
    check("rst_active", io_active, 0);
    check("rst_uflow", underflow_cnt, 0);
    check("rst_io", io_out, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    #1 check_reset_state();
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send(input logic [15:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!acc && n < 20) begin
      #4 acc = s_ready;
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    check("send_accept", acc, 1);
  endtask

  initial begin
    logic        acc;
    logic [15:0] d;
    int          act_n;
    int          n;

    do_reset();

    // Two words, prime at level 2, then underflow.
    en = 1'b1;
    send(16'hA1B2);
    send(16'hC3D4);
    act_n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t1_level", fifo_level, t1_lvl[i]);
      check("t1_active", io_active, t1_act[i]);
      if (io_active) act_n++;
      @(negedge clk);
    end
    check("t1_active_cycles", act_n, 2);
    en = 1'b0;
    do_reset();

    // Preload while disabled.
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    send(16'h4444);
    #1;
    check("t2_level", fifo_level, 4);
    check("t2_ready", s_ready, 0);
    check("t2_active", io_active, 0);
    check("t2_io", io_out, 8'h00);
    @(negedge clk);

    // Enable while full with a continuous source.
    d = 16'h5000;
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_data = d;
      #4;
      check("t3_ready", s_ready, (k >= 2));
      check("t3_level", fifo_level, 4);
      check("t3_active", io_active, (k >= 3));
      acc = s_ready;
      @(negedge clk);
      if (acc) d++;
    end
    s_valid = 1'b0;

    // Starve: four words drain, then five underflow cycles.
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk); #1;
      check("t4_level", fifo_level, (i < 4) ? 4 - i : 0);
      check("t4_uflow", underflow_cnt, (i < 5) ? 0 : i - 4);
    end
    @(negedge clk);
    send(16'h6001);
    send(16'h6002);

    // Long underflow saturates the counter.
    repeat (300) @(negedge clk);
    #1 check("t5_uflow_sat", underflow_cnt, 255);
    @(negedge clk);

    // Reset in the high phase while a word is on the bus.
    send(16'h7001);
    send(16'h7002);
    send(16'h7003);
    @(posedge clk);
    @(posedge clk);
    #2 check("t6_lo_before_rst", io_out, 8'h01);
    #1 rst = 1'b1;
    #1 check_reset_state();
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);

    send(16'h8001);
    send(16'h8002);
    #1;
    check("t6_prime_active", io_active, 0);
    check("t6_prime_level", fifo_level, 2);
    n = 0;
    while ((exp_q.size() != 0 || pending) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
